// File: rtl/ball_bounce_multi.sv
// Multi-ball bouncing renderer.
// Holds NUM_BALLS square balls. Each ball has its own position and velocity.
// Once per frame an FSM steps the balls one per clock and reflects each one
// off the edges of the active area. A registered 3-bit pixel is produced from
// the sync generator's hpos/vpos/visible.

// Single-axis step for one ball: add the velocity, then reflect off [0, LIM].
module ball_bounce_axis #(
    parameter int LIM   = 636,
    parameter int SPEED = 1
) (
    input  logic [9:0] p,
    input  logic [3:0] v,
    output logic [9:0] np,
    output logic [3:0] nv,
    output logic       refl
);
    localparam logic [3:0]  V_POS = 4'(SPEED);
    localparam logic [3:0]  V_NEG = 4'(-SPEED);
    localparam logic [10:0] LIM_W = 11'(LIM);

    // 11-bit two's complement sum. Bit 10 set means the ball stepped below zero.
    logic [10:0] n;
    assign n = {1'b0, p} + {{7{v[3]}}, v};

    // Clamp to the edge and flip the direction whenever the step overshoots.
    always_comb begin
        np   = n[9:0];
        nv   = v;
        refl = 1'b0;
        if (!n[10] && n > LIM_W) begin
            np   = LIM_W[9:0];
            nv   = V_NEG;
            refl = 1'b1;
        end else if (n[10]) begin
            np   = 10'd0;
            nv   = V_POS;
            refl = 1'b1;
        end
    end
endmodule

module ball_bounce_multi #(
    parameter int         NUM_BALLS        = 4,
    parameter int         BALL_SIZE        = 4,
    parameter int         SPEED            = 1,
    parameter int         H_ACTIVE         = 640,
    parameter int         V_ACTIVE         = 480,
    parameter int         VSYNC_ACTIVE_LOW = 1,
    parameter logic [2:0] BG_RGB           = 3'b000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_vsync,
    input  logic       i_visible,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    input  logic       i_pause,
    output logic [2:0] o_rgb,
    output logic       o_busy,
    output logic [7:0] o_bounces
);
    localparam int         IW      = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_BALLS - 1);
    localparam logic [3:0] V_POS   = 4'(SPEED);
    localparam logic [3:0] V_NEG   = 4'(-SPEED);
    localparam logic       VS_IDLE = (VSYNC_ACTIVE_LOW != 0);

    // Elaboration guards: parameter ranges, and every starting ball inside the screen.
    if (NUM_BALLS < 1 || NUM_BALLS > 8 || BALL_SIZE < 1 || BALL_SIZE > 63 ||
        SPEED < 1 || SPEED > 7) begin : g_bad_param
        $error("ball_bounce_multi: parameter out of range");
    end
    for (genvar k = 0; k < NUM_BALLS; k++) begin : g_chk
        if (32 + 48*k + BALL_SIZE > H_ACTIVE || 32 + 32*k + BALL_SIZE > V_ACTIVE) begin : g_bad
            $error("ball_bounce_multi: initial ball outside active area");
        end
    end

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t                        state;
    logic [IW-1:0]                 idx;
    logic                          vsync_q;
    logic [NUM_BALLS-1:0][9:0]     pos_x, pos_y;
    logic [NUM_BALLS-1:0][3:0]     vel_x, vel_y;

    // The frame tick fires on the asserting edge of vsync.
    logic tick;
    assign tick = VS_IDLE ? (vsync_q & ~i_vsync) : (~vsync_q & i_vsync);

    // Select the ball that is being updated this cycle.
    logic [9:0] cur_x, cur_y;
    logic [3:0] cur_vx, cur_vy;
    always_comb begin
        cur_x  = pos_x[0];
        cur_y  = pos_y[0];
        cur_vx = vel_x[0];
        cur_vy = vel_y[0];
        for (int k = 1; k < NUM_BALLS; k++) begin
            if (int'(idx) == k) begin
                cur_x  = pos_x[k];
                cur_y  = pos_y[k];
                cur_vx = vel_x[k];
                cur_vy = vel_y[k];
            end
        end
    end

    logic [9:0] nx, ny;
    logic [3:0] nvx, nvy;
    logic       rx, ry;

    ball_bounce_axis #(.LIM(H_ACTIVE - BALL_SIZE), .SPEED(SPEED)) u_ax_x (
        .p(cur_x), .v(cur_vx), .np(nx), .nv(nvx), .refl(rx)
    );
    ball_bounce_axis #(.LIM(V_ACTIVE - BALL_SIZE), .SPEED(SPEED)) u_ax_y (
        .p(cur_y), .v(cur_vy), .np(ny), .nv(nvy), .refl(ry)
    );

    // Per-ball coverage test against the current beam position.
    logic [NUM_BALLS-1:0] hit;
    for (genvar k = 0; k < NUM_BALLS; k++) begin : g_hit
        assign hit[k] = ({1'b0, i_hpos} >= {1'b0, pos_x[k]}) &&
                        ({1'b0, i_hpos} <  {1'b0, pos_x[k]} + 11'(BALL_SIZE)) &&
                        ({1'b0, i_vpos} >= {1'b0, pos_y[k]}) &&
                        ({1'b0, i_vpos} <  {1'b0, pos_y[k]} + 11'(BALL_SIZE));
    end

    // Choose the pixel colour. The scan runs from high index down, so the lowest covering index wins.
    logic [2:0] pix;
    always_comb begin
        pix = BG_RGB;
        for (int k = NUM_BALLS - 1; k >= 0; k--) begin
            if (hit[k]) pix = 3'((k % 7) + 1);
        end
        if (!i_visible) pix = 3'b000;
    end

    // Register vsync for edge detection, and register the pixel output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vsync_q <= VS_IDLE;
            o_rgb   <= 3'b000;
        end else begin
            vsync_q <= i_vsync;
            o_rgb   <= pix;
        end
    end

    // Frame FSM: while idle, wait for a tick; then update one ball per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            o_busy    <= 1'b0;
            o_bounces <= 8'd0;
            for (int k = 0; k < NUM_BALLS; k++) begin
                pos_x[k] <= 10'(32 + 48*k);
                pos_y[k] <= 10'(32 + 32*k);
                vel_x[k] <= (k % 2 == 0) ? V_POS : V_NEG;
                vel_y[k] <= V_POS;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (tick && !i_pause) begin
                        state  <= UPDATE;
                        idx    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                UPDATE: begin
                    for (int k = 0; k < NUM_BALLS; k++) begin
                        if (int'(idx) == k) begin
                            pos_x[k] <= nx;
                            pos_y[k] <= ny;
                            vel_x[k] <= nvx;
                            vel_y[k] <= nvy;
                        end
                    end
                    // A corner hit counts as one bounce, not two.
                    if (rx || ry) o_bounces <= o_bounces + 8'd1;
                    if (idx == LAST) begin
                        state  <= IDLE;
                        idx    <= '0;
                        o_busy <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_bounce_multi.sv
// Directed bench for ball_bounce_multi. Four instances share the inputs:
// the default configuration, large balls (overlap priority), a narrow screen
// (right-edge bounce) and a small square screen (corner bounce).
module tb_ball_bounce_multi;
    logic       clk = 1'b0;
    logic       rst_n, vsync, visible, pause;
    logic [9:0] hpos, vpos;
    logic [2:0] rgb_m, rgb_b, rgb_e, rgb_c;
    logic       busy_m, busy_b, busy_e, busy_c;
    logic [7:0] bnc_m, bnc_b, bnc_e, bnc_c;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ball_bounce_multi dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_visible(visible),
        .i_hpos(hpos), .i_vpos(vpos), .i_pause(pause),
        .o_rgb(rgb_m), .o_busy(busy_m), .o_bounces(bnc_m));

    ball_bounce_multi #(.BALL_SIZE(60)) dut_big (
        .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_visible(visible),
        .i_hpos(hpos), .i_vpos(vpos), .i_pause(pause),
        .o_rgb(rgb_b), .o_busy(busy_b), .o_bounces(bnc_b));

    ball_bounce_multi #(.NUM_BALLS(1), .H_ACTIVE(40)) dut_edge (
        .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_visible(visible),
        .i_hpos(hpos), .i_vpos(vpos), .i_pause(pause),
        .o_rgb(rgb_e), .o_busy(busy_e), .o_bounces(bnc_e));

    ball_bounce_multi #(.NUM_BALLS(1), .H_ACTIVE(40), .V_ACTIVE(40)) dut_corner (
        .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_visible(visible),
        .i_hpos(hpos), .i_vpos(vpos), .i_pause(pause),
        .o_rgb(rgb_c), .o_busy(busy_c), .o_bounces(bnc_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One asserting (falling) vsync edge, then a count of busy cycles over a bounded window.
    task automatic do_tick(output int bm, output int be);
        @(negedge clk);
        vsync = 1'b0;
        bm = 0;
        be = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) vsync = 1'b1;
            bm += int'(busy_m);
            be += int'(busy_e);
        end
    endtask

    typedef struct {
        bit         big;
        bit         vis;
        int         h;
        int         v;
        logic [2:0] exp;
        string      name;
    } rvec_t;

    rvec_t tbl[12];

    initial begin
        int bm, be;
        tbl[0]  = '{0, 1,  33,  34, 3'b001, "rgb_ball0"};
        tbl[1]  = '{0, 1, 100,  34, 3'b000, "rgb_bg"};
        tbl[2]  = '{0, 0,  33,  34, 3'b000, "rgb_invisible"};
        tbl[3]  = '{0, 1,  80,  64, 3'b010, "rgb_ball1_corner"};
        tbl[4]  = '{0, 1,  83,  67, 3'b010, "rgb_ball1_far"};
        tbl[5]  = '{0, 1,  84,  67, 3'b000, "rgb_ball1_excl"};
        tbl[6]  = '{0, 1, 128,  96, 3'b011, "rgb_ball2"};
        tbl[7]  = '{0, 1, 179, 131, 3'b100, "rgb_ball3"};
        tbl[8]  = '{0, 1,  31,  32, 3'b000, "rgb_left_of_ball0"};
        tbl[9]  = '{1, 1,  85,  70, 3'b001, "big_overlap01"};
        tbl[10] = '{1, 1, 100,  70, 3'b010, "big_ball1"};
        tbl[11] = '{1, 1, 139, 123, 3'b010, "big_overlap12"};

        rst_n = 1'b0; vsync = 1'b1; visible = 1'b0; pause = 1'b0; hpos = '0; vpos = '0;
        #12;
        chk("reset_rgb", 32'(rgb_m), 0);
        chk("reset_busy", 32'(busy_m), 0);
        chk("reset_bounces", 32'(bnc_m), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Rendering vectors, applied with the reset positions in place.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            visible = tbl[i].vis;
            hpos = 10'(tbl[i].h);
            vpos = 10'(tbl[i].v);
            @(posedge clk);
            #1;
            chk(tbl[i].name, 32'(tbl[i].big ? rgb_b : rgb_m), 32'(tbl[i].exp));
        end
        visible = 1'b0;

        // First frame step.
        do_tick(bm, be);
        chk("busy_cycles_4", bm, 4);
        chk("busy_cycles_1", be, 1);
        chk("f1_b0_x", 32'(dut.pos_x[0]), 33);
        chk("f1_b0_y", 32'(dut.pos_y[0]), 33);
        chk("f1_b1_x", 32'(dut.pos_x[1]), 79);
        chk("f1_b1_y", 32'(dut.pos_y[1]), 65);
        chk("f1_bounces", 32'(bnc_m), 0);

        // Ticks 2 to 4: both small-screen balls reach their limits.
        for (int t = 2; t <= 4; t++) do_tick(bm, be);
        chk("edge_t4_x", 32'(dut_edge.pos_x[0]), 36);
        chk("edge_t4_bnc", 32'(bnc_e), 0);
        chk("corner_t4_x", 32'(dut_corner.pos_x[0]), 36);
        chk("corner_t4_y", 32'(dut_corner.pos_y[0]), 36);

        do_tick(bm, be);
        chk("edge_t5_x", 32'(dut_edge.pos_x[0]), 36);
        chk("edge_t5_bnc", 32'(bnc_e), 1);
        chk("corner_t5_x", 32'(dut_corner.pos_x[0]), 36);
        chk("corner_t5_y", 32'(dut_corner.pos_y[0]), 36);
        chk("corner_t5_bnc", 32'(bnc_c), 1);

        do_tick(bm, be);
        chk("edge_t6_x", 32'(dut_edge.pos_x[0]), 35);
        chk("edge_t6_bnc", 32'(bnc_e), 1);
        chk("corner_t6_x", 32'(dut_corner.pos_x[0]), 35);
        chk("corner_t6_y", 32'(dut_corner.pos_y[0]), 35);
        chk("corner_t6_bnc", 32'(bnc_c), 1);

        // Pause: ticks are ignored and the 6-frame positions stay put.
        pause = 1'b1;
        for (int t = 0; t < 3; t++) begin
            do_tick(bm, be);
            chk("pause_busy", bm, 0);
        end
        for (int k = 0; k < 4; k++) begin
            chk("pause_x", 32'(dut.pos_x[k]), 32'(32 + 48*k + ((k % 2 == 0) ? 6 : -6)));
            chk("pause_y", 32'(dut.pos_y[k]), 32'(32 + 32*k + 6));
        end

        // Pause raised after the sequence has started does not cut it short.
        pause = 1'b0;
        @(negedge clk);
        vsync = 1'b0;
        bm = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                vsync = 1'b1;
                pause = 1'b1;
            end
            bm += int'(busy_m);
        end
        chk("late_pause_busy", bm, 4);
        chk("f7_b1_x", 32'(dut.pos_x[1]), 73);
        chk("f7_b3_y", 32'(dut.pos_y[3]), 135);

        // Reset asserted during the second UPDATE cycle.
        pause = 1'b0;
        @(negedge clk);
        vsync = 1'b0;
        @(posedge clk);
        #1;
        vsync = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(busy_m), 1);
        chk("mid_b0_updated", 32'(dut.pos_x[0]), 40);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy_m), 0);
        chk("rst_b0_x", 32'(dut.pos_x[0]), 32);
        chk("rst_b1_y", 32'(dut.pos_y[1]), 64);
        chk("rst_b1_vx", 32'(dut.vel_x[1]), 32'h0000000F);
        chk("rst_b0_vx", 32'(dut.vel_x[0]), 1);
        chk("rst_edge_bnc", 32'(bnc_e), 0);
        chk("rst_corner_x", 32'(dut_corner.pos_x[0]), 32);
        #7;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
